// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC register, next-PC select, RUN/STALL/HALT control.
// Ports: clk, reset (sync, active-high), stall, branchTaken, branchOffset,
//   jump, jumpTarget, instructionIn -> pcOut, pcPlus4, halted,
//   retiredCount, fault. Macro PC_RANGE_TRAP_EN enables the PC range trap.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_BYTES = 128,
  parameter logic [31:0] HALT_WORD = 32'h0000_000C
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branchTaken,
  input  logic [15:0] branchOffset,
  input  logic        jump,
  input  logic [25:0] jumpTarget,
  input  logic [31:0] instructionIn,
  output logic [31:0] pcOut,
  output logic [31:0] pcPlus4,
  output logic        halted,
  output logic [31:0] retiredCount,
  output logic        fault
);

`ifdef PC_RANGE_TRAP_EN
  localparam bit trap_en = 1'b1;
`else
  localparam bit trap_en = 1'b0;
`endif

  typedef enum logic [1:0] {
    RUN,
    STALL,
    HALT
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic [31:0] br_disp;
  logic        pc_bad;
  logic        halted_q;
  logic        fault_q;
  logic [31:0] count;

  assign pcPlus4 = pc + 32'd4;

  // Word offset sign-extended and scaled to bytes.
  assign br_disp = {{14{branchOffset[15]}}, branchOffset, 2'b00};

  always_comb begin
    pc_next = pcPlus4;
    if (jump)
      pc_next = {pcPlus4[31:28], jumpTarget, 2'b00};
    else if (branchTaken)
      pc_next = pcPlus4 + br_disp;
  end

  assign pc_bad = (pc_next >= 32'(MEM_BYTES)) ||
                  (pc_next[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= RUN;
      pc       <= RESET_PC;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
      count    <= 32'd0;
    end else begin
      unique case (state)
        HALT: begin
          state <= HALT;
        end
        default: begin
          if (stall) begin
            state <= STALL;
          end else if (instructionIn == HALT_WORD) begin
            state    <= HALT;
            halted_q <= 1'b1;
          end else if (trap_en && pc_bad) begin
            // Illegal target is never loaded; PC stays on the offender.
            state    <= HALT;
            halted_q <= 1'b1;
            fault_q  <= 1'b1;
          end else begin
            state <= RUN;
            pc    <= pc_next;
            count <= count + 32'd1;
          end
        end
      endcase
    end
  end

  assign pcOut        = pc;
  assign halted       = halted_q;
  assign retiredCount = count;
  assign fault        = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit.
// Steps through sequential, branch, jump, stall, halt, wrap and reset cases.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        branchTaken;
  logic [15:0] branchOffset;
  logic        jump;
  logic [25:0] jumpTarget;
  logic [31:0] instructionIn;
  logic [31:0] pcOut;
  logic [31:0] pcPlus4;
  logic        halted;
  logic [31:0] retiredCount;
  logic        fault;

  int checks;
  int errors;

  fetch_unit dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .branchTaken  (branchTaken),
    .branchOffset (branchOffset),
    .jump         (jump),
    .jumpTarget   (jumpTarget),
    .instructionIn(instructionIn),
    .pcOut        (pcOut),
    .pcPlus4      (pcPlus4),
    .halted       (halted),
    .retiredCount (retiredCount),
    .fault        (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_ctl();
    stall        = 1'b0;
    branchTaken  = 1'b0;
    branchOffset = 16'h0000;
    jump         = 1'b0;
    jumpTarget   = 26'h0;
  endtask

  localparam logic [31:0] NOP = 32'h2008_000A;

  initial begin
    checks = 0;
    errors = 0;
    clear_ctl();
    instructionIn = NOP;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    check("rst_pc", pcOut, 32'd0);
    check("rst_cnt", retiredCount, 32'd0);
    check("rst_halt", {31'd0, halted}, 32'd0);
    check("rst_fault", {31'd0, fault}, 32'd0);
    check("rst_pc4", pcPlus4, 32'd4);

    step(); check("seq_4", pcOut, 32'd4);
    step(); check("seq_8", pcOut, 32'd8);
    step(); check("seq_12", pcOut, 32'd12);
    check("seq_cnt", retiredCount, 32'd3);

    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_pc", pcOut, 32'd12);
      check("stall_cnt", retiredCount, 32'd3);
    end
    stall = 1'b0;
    step(); check("unstall_pc", pcOut, 32'd16);
    check("unstall_cnt", retiredCount, 32'd4);

    step(); step(); step();
    check("pc_28", pcOut, 32'd28);
    branchTaken = 1'b1; branchOffset = 16'h0002;
    step(); check("br_fwd", pcOut, 32'd40);
    clear_ctl();
    jump = 1'b1; jumpTarget = 26'h7;
    step(); check("jmp_28", pcOut, 32'd28);
    clear_ctl();
    branchTaken = 1'b1; branchOffset = 16'hFFF8;
    step(); check("br_back", pcOut, 32'd0);
    clear_ctl();

    step(); step();
    check("pc_8", pcOut, 32'd8);
    jump = 1'b1; jumpTarget = 26'h4;
    branchTaken = 1'b1; branchOffset = 16'h0002;
    step(); check("jmp_wins", pcOut, 32'd16);
    clear_ctl();
    step(); check("pc_20", pcOut, 32'd20);
    check("cnt_14", retiredCount, 32'd14);

    instructionIn = 32'h0000_000C;
    step();
    check("halt_flag", {31'd0, halted}, 32'd1);
    check("halt_pc", pcOut, 32'd20);
    instructionIn = NOP;
    jump = 1'b1; jumpTarget = 26'h10;
    branchTaken = 1'b1; branchOffset = 16'h0004;
    stall = 1'b1;
    step(); step();
    check("halt_hold_pc", pcOut, 32'd20);
    check("halt_hold_cnt", retiredCount, 32'd14);
    check("halt_hold_flag", {31'd0, halted}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    clear_ctl();
    check("halt_rst_pc", pcOut, 32'd0);
    check("halt_rst_flag", {31'd0, halted}, 32'd0);
    check("halt_rst_cnt", retiredCount, 32'd0);

`ifndef PC_RANGE_TRAP_EN
    branchTaken = 1'b1; branchOffset = 16'hFFFE;
    step(); check("br_neg", pcOut, 32'hFFFF_FFFC);
    check("pc4_wrap", pcPlus4, 32'd0);
    clear_ctl();
    step(); check("seq_wrap", pcOut, 32'd0);
    jump = 1'b1; jumpTarget = 26'h20;
    step(); check("jmp_128", pcOut, 32'd128);
    check("no_fault", {31'd0, fault}, 32'd0);
    clear_ctl();
`else
    jump = 1'b1; jumpTarget = 26'h20;
    step(); check("trap_pc", pcOut, 32'd0);
    check("trap_fault", {31'd0, fault}, 32'd1);
    check("trap_halt", {31'd0, halted}, 32'd1);
    check("trap_cnt", retiredCount, 32'd0);
    clear_ctl();
    step(); check("trap_hold", pcOut, 32'd0);
`endif

    stall = 1'b1;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    stall = 1'b0;
    check("mid_rst_pc", pcOut, 32'd0);
    check("mid_rst_fault", {31'd0, fault}, 32'd0);
    check("mid_rst_halt", {31'd0, halted}, 32'd0);
    step(); check("post_rst_pc", pcOut, 32'd4);
    check("post_rst_cnt", retiredCount, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, byte address loaded into PC on reset.
REQ-002 Parameter MEM_BYTES, default 128, size in bytes of the downstream instruction memory (32 words).
REQ-003 Parameter HALT_WORD, default 32'h0000000C (syscall), instruction encoding that halts fetch.
REQ-004 Port clk  input  1  single rising-edge clock.
REQ-005 Port reset  input  1  synchronous, active-high reset.
REQ-006 Port stall  input  1  hold PC and state this cycle.
REQ-007 Port branchTaken  input  1  take the branch this cycle.
REQ-008 Port branchOffset  input  16  signed word offset from the branch immediate field.
REQ-009 Port jump  input  1  take the jump this cycle.
REQ-010 Port jumpTarget  input  26  J-format target field.
REQ-011 Port instructionIn  input  32  word returned by the instruction memory for pcOut.
REQ-012 Port pcOut  output  32  current PC; drives the instruction memory select input.
REQ-013 Port pcPlus4  output  32  pcOut + 4, combinational.
REQ-014 Port halted  output  1  high while in HALT.
REQ-015 Port retiredCount  output  32  number of PC advances since reset.
REQ-016 Port fault  output  1  PC range/alignment trap flag.

Function
REQ-017 States SHALL be RUN, STALL, HALT; encoding is free.
REQ-018 Per-cycle priority SHALL be: reset > stall > halt detect > jump > branch > sequential.
REQ-019 RUN with stall=1 SHALL go to STALL, holding PC and retiredCount.
REQ-020 STALL with stall=1 SHALL stay; with stall=0 it SHALL return to RUN and apply the normal next-PC selection that same cycle.
REQ-021 RUN/STALL with stall=0 and instructionIn==HALT_WORD SHALL go to HALT, holding PC at the halt instruction address.
REQ-022 HALT SHALL ignore stall, jump and branchTaken; only reset leaves it.
REQ-023 Jump next PC SHALL be {pcPlus4[31:28], jumpTarget, 2'b00}.
REQ-024 Branch next PC SHALL be pcPlus4 + (sign-extended branchOffset << 2), computed modulo 2^32.
REQ-025 Sequential next PC SHALL be pcPlus4; 32'hFFFFFFFC wraps to 32'h00000000.
REQ-026 Simultaneous jump and branchTaken SHALL select the jump.
REQ-027 PC SHALL update only on the rising clk edge; pcOut is the registered value, zero-latency to memory.
REQ-028 retiredCount SHALL increment by 1 on each PC update in RUN/STALL and wrap modulo 2^32.

Reset
REQ-029 reset=1 at an edge SHALL set pcOut=RESET_PC, state=RUN, halted=0, retiredCount=0, fault=0, overriding all inputs including mid-stall and HALT.
REQ-030 The first cycle after reset SHALL present RESET_PC to memory with normal fetch enabled.

Configuration
REQ-031 Macro PC_RANGE_TRAP_EN: when defined, a selected next PC >= MEM_BYTES or with bits[1:0] != 0 SHALL NOT be loaded; state goes to HALT, fault=1, retiredCount held.
REQ-032 Without PC_RANGE_TRAP_EN, fault SHALL be tied to 0 and any next PC SHALL be loaded; the memory aliases addresses through its word-index bits.

Verification
REQ-033 Reset, instructionIn=32'h2008000A, no control for 3 cycles -> pcOut 0,4,8,12; retiredCount=3.
REQ-034 At pcOut=28 assert branchTaken, branchOffset=16'h0002 -> next pcOut=40; with branchOffset=16'hFFF8 -> next pcOut=0.
REQ-035 At pcOut=8 assert jump, jumpTarget=26'h0000004, branchTaken=1 -> next pcOut=16 (jump wins).
REQ-036 stall=1 for 3 cycles at pcOut=12 -> pcOut and retiredCount constant; release -> pcOut=16 on the next edge.
REQ-037 instructionIn=32'h0000000C at pcOut=20 -> halted=1, pcOut stays 20 despite jump/branch; reset -> pcOut=0, halted=0.
REQ-038 PC_RANGE_TRAP_EN defined, jump to 26'h0000020 (byte 128) -> fault=1, halted=1, pcOut unchanged; undefined -> pcOut=128, fault=0.
